// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a controller and the PS/2 host transmitter.
// master = requesting controller, slave = ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy,
    output tx_done,
    output tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte over open-drain clock/data.
// Optional device-clock watchdog enabled by defining PS2_TX_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | host holds ps2 clock low for INHIBIT_CYCLES cycles
// REQ       | start bit (data low) asserted while clock still held, 1 cycle
// SEND      | clock released; present next frame bit on each device falling edge
// ACK       | wait for 11th falling edge and sample device acknowledge
// WAIT_IDLE | wait for device to release both lines, then report done
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic            clock,
  input  logic            reset,
  ps2_host_tx_if.slave    tx,
  input  logic            ps2_clock_in,
  input  logic            ps2_data_in,
  output logic            ps2_clock_oe,
  output logic            ps2_data_oe
);

  // One down-counter serves both the inhibit interval and the watchdog.
  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES
                                                                      : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [9:0]       shift_q,     shift_d;
  logic [3:0]       bit_cnt_q,   bit_cnt_d;
  logic             clock_oe_q,  clock_oe_d;
  logic             data_oe_q,   data_oe_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             error_q,     error_d;
  logic             clk_meta_q,  clk_meta_d;
  logic             clk_sync_q,  clk_sync_d;
  logic             clk_prev_q,  clk_prev_d;
  logic             data_meta_q, data_meta_d;
  logic             data_sync_q, data_sync_d;
  logic             clk_fall;

  assign clk_fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    clock_oe_d  = clock_oe_q;
    data_oe_d   = data_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    clk_meta_d  = ps2_clock_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;

    case (state_q)
      S_IDLE: begin
        if (tx.tx_start) begin
          shift_d    = {1'b1, ~^tx.tx_data, tx.tx_data};
          bit_cnt_d  = 4'd0;
          cnt_d      = CNT_W'(INHIBIT_CYCLES - 1);
          clock_oe_d = 1'b1;
          data_oe_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == '0) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_REQ: begin
        clock_oe_d = 1'b0;
        bit_cnt_d  = 4'd0;
        cnt_d      = CNT_W'(TIMEOUT_CYCLES - 1);
        state_d    = S_SEND;
      end

      S_SEND: begin
        // Device samples on its rising edge, so each bit changes while clock is low.
        if (clk_fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b1, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        if (clk_fall) begin
          if (data_sync_q) begin
            error_d   = 1'b1;
            busy_d    = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog restarts on every device edge; expiry overrides any other outcome.
    if (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
      if (clk_fall) begin
        cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
      end else if (cnt_q == '0) begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b1;
        state_d    = S_IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
`else
    // Without the watchdog the block waits for device edges indefinitely.
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      clock_oe_q  <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      clock_oe_q  <= clock_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign ps2_clock_oe = clock_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign tx.tx_busy   = busy_q;
  assign tx.tx_done   = done_q;
  assign tx.tx_error  = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// the observed bit stream and outcome are compared to a byte-level frame model.
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic dev_clk;
  logic dev_data;
  logic ps2_clock_in;
  logic ps2_data_in;
  logic ps2_clock_oe;
  logic ps2_data_oe;

  ps2_host_tx_if txif();

  // Open-drain wires: either side pulling low wins.
  assign ps2_clock_in = ps2_clock_oe ? 1'b0 : dev_clk;
  assign ps2_data_in  = ps2_data_oe  ? 1'b0 : dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .tx           (txif),
    .ps2_clock_in (ps2_clock_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clock_oe (ps2_clock_oe),
    .ps2_data_oe  (ps2_data_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int coe_rise_cyc = 0;
  int coe_fall_cyc = 0;
  int coe_len = 0;
  int doe_rise_cyc = 0;
  int last_fall_cyc = 0;
  bit prev_coe = 1'b0;
  bit prev_doe = 1'b0;
  bit prev_busy = 1'b0;
  bit pulse_busy_ok = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ps2_clock_oe && !prev_coe) coe_rise_cyc = cyc;
    if (!ps2_clock_oe && prev_coe) begin
      coe_fall_cyc = cyc;
      coe_len      = cyc - coe_rise_cyc;
    end
    if (ps2_data_oe && !prev_doe && ps2_clock_oe) doe_rise_cyc = cyc;
    if (txif.tx_done === 1'b1) n_done = n_done + 1;
    if (txif.tx_error === 1'b1) n_err = n_err + 1;
    if (txif.tx_done === 1'b1 || txif.tx_error === 1'b1)
      pulse_busy_ok = (txif.tx_busy === 1'b0) && prev_busy;
    prev_coe  = ps2_clock_oe;
    prev_doe  = ps2_data_oe;
    prev_busy = (txif.tx_busy === 1'b1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as the device should see it: data LSB first, odd parity, stop = 1.
  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = d[i];
    f[8] = (($countones(d) % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input int n_edges, input bit ack_low,
                      input bit second_req, output logic [9:0] seen);
    int  waited;
    int  base;
    seen = '0;
    txif.tx_data  = d;
    txif.tx_start = 1'b1;
    tick(1);
    txif.tx_start = 1'b0;
    txif.tx_data  = 8'($urandom);
    if (second_req) begin
      tick(5);
      txif.tx_data  = 8'h55;
      txif.tx_start = 1'b1;
      tick(1);
      txif.tx_start = 1'b0;
    end
    waited = 0;
    while (!(ps2_clock_oe === 1'b0 && ps2_data_oe === 1'b1) && waited < INH + 20) begin
      tick(1);
      waited++;
    end
    if (waited >= INH + 20) check("release_wait", 32'(waited), 32'(INH + 19));
    base = n_done + n_err;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) dev_data = ack_low ? 1'b0 : 1'b1;
      tick(6);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      tick(8);
      if (k <= 10) seen[k-1] = ps2_data_in;
      dev_clk = 1'b1;
    end
    if (n_edges == 11) begin
      tick(4);
      dev_data = 1'b1;
      waited = 0;
      while (n_done + n_err == base && waited < 40) begin
        tick(1);
        waited++;
      end
      tick(2);
    end
  endtask

  logic [9:0] seen;
  logic [7:0] rb;
  bit         rack;
  int         d0, e0;
  int         waited;
  int         err_cyc;

  initial begin
    reset         = 1'b1;
    dev_clk       = 1'b1;
    dev_data      = 1'b1;
    txif.tx_data  = 8'h00;
    txif.tx_start = 1'b0;
    tick(3);
    check("rst_busy",  32'(txif.tx_busy),  32'd0);
    check("rst_done",  32'(txif.tx_done),  32'd0);
    check("rst_error", 32'(txif.tx_error), 32'd0);
    check("rst_coe",   32'(ps2_clock_oe),  32'd0);
    check("rst_doe",   32'(ps2_data_oe),   32'd0);

    // Request coinciding with reset must be dropped.
    txif.tx_data  = 8'hA5;
    txif.tx_start = 1'b1;
    tick(1);
    reset         = 1'b0;
    txif.tx_start = 1'b0;
    tick(3);
    check("start_in_reset_busy", 32'(txif.tx_busy), 32'd0);
    check("start_in_reset_coe",  32'(ps2_clock_oe), 32'd0);

    // Line activity while idle.
    for (int i = 0; i < 3; i++) begin
      dev_clk  = 1'b0;
      dev_data = 1'(i);
      tick(5);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      tick(5);
    end
    check("idle_noise_busy",   32'(txif.tx_busy),  32'd0);
    check("idle_noise_oe",     32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
    check("idle_noise_pulses", 32'(n_done + n_err), 32'd0);

    // 0xED with ack.
    d0 = n_done; e0 = n_err; pulse_busy_ok = 1'b0;
    send(8'hED, 11, 1'b1, 1'b0, seen);
    check("ed_bits",      32'(seen), 32'(frame_bits(8'hED)));
    check("ed_done",      32'(n_done - d0), 32'd1);
    check("ed_err",       32'(n_err - e0),  32'd0);
    check("ed_busy_fall", 32'(pulse_busy_ok), 32'd1);
    check("ed_idle_busy", 32'(txif.tx_busy), 32'd0);

    // 0x00: inhibit length and start-bit ordering.
    d0 = n_done; e0 = n_err;
    send(8'h00, 11, 1'b1, 1'b0, seen);
    check("zero_bits",     32'(seen), 32'(frame_bits(8'h00)));
    check("zero_parity",   32'(seen[8]), 32'd1);
    check("zero_coe_len",  32'(coe_len), 32'(INH + 1));
    check("zero_doe_lead", 32'(coe_fall_cyc - doe_rise_cyc), 32'd1);
    check("zero_done",     32'(n_done - d0), 32'd1);

    // 0xFF without ack.
    d0 = n_done; e0 = n_err; pulse_busy_ok = 1'b0;
    send(8'hFF, 11, 1'b0, 1'b0, seen);
    check("ff_bits",      32'(seen), 32'(frame_bits(8'hFF)));
    check("ff_err",       32'(n_err - e0),  32'd1);
    check("ff_done",      32'(n_done - d0), 32'd0);
    check("ff_busy_fall", 32'(pulse_busy_ok), 32'd1);
    check("ff_idle",      32'({txif.tx_busy, ps2_clock_oe, ps2_data_oe}), 32'd0);

    // 0xF4 with a second request issued while busy.
    d0 = n_done; e0 = n_err;
    send(8'hF4, 11, 1'b1, 1'b1, seen);
    check("f4_bits", 32'(seen), 32'(frame_bits(8'hF4)));
    check("f4_done", 32'(n_done - d0), 32'd1);
    tick(INH + 10);
    check("f4_no_second", 32'({txif.tx_busy, ps2_clock_oe}), 32'd0);

    // Reset after edge 5.
    d0 = n_done; e0 = n_err;
    send(8'h3C, 5, 1'b1, 1'b0, seen);
    check("abort_busy_before", 32'(txif.tx_busy), 32'd1);
    reset = 1'b1;
    tick(1);
    check("abort_oe",     32'({ps2_clock_oe, ps2_data_oe}), 32'd0);
    check("abort_busy",   32'(txif.tx_busy), 32'd0);
    check("abort_pulses", 32'({txif.tx_done, txif.tx_error}), 32'd0);
    reset = 1'b0;
    tick(4);
    check("abort_no_pulse_count", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    d0 = n_done; e0 = n_err;
    send(8'hED, 11, 1'b1, 1'b0, seen);
    check("after_abort_bits", 32'(seen), 32'(frame_bits(8'hED)));
    check("after_abort_done", 32'(n_done - d0), 32'd1);

    // Randomized bytes and acknowledge behaviour.
    for (int i = 0; i < 6; i++) begin
      rb   = 8'($urandom);
      rack = 1'($urandom_range(0, 1));
      d0 = n_done; e0 = n_err;
      send(rb, 11, rack, 1'b0, seen);
      check($sformatf("rnd%0d_bits", i), 32'(seen), 32'(frame_bits(rb)));
      check($sformatf("rnd%0d_done", i), 32'(n_done - d0), 32'(rack));
      check($sformatf("rnd%0d_err", i),  32'(n_err - e0),  32'(!rack));
    end

    // Device stops clocking after edge 4.
    d0 = n_done; e0 = n_err;
    send(8'h5A, 4, 1'b1, 1'b0, seen);
`ifdef PS2_TX_TIMEOUT_EN
    waited = 0;
    while (n_err == e0 && waited < TMO + 50) begin
      tick(1);
      waited++;
    end
    err_cyc = cyc;
    check("tmo_err", 32'(n_err - e0), 32'd1);
    check("tmo_latency_window",
          32'((err_cyc - last_fall_cyc >= TMO) && (err_cyc - last_fall_cyc <= TMO + 5)), 32'd1);
    check("tmo_released", 32'({ps2_clock_oe, ps2_data_oe, txif.tx_busy}), 32'd0);
`else
    waited = 0;
    while (n_err == e0 && waited < TMO + 100) begin
      tick(1);
      waited++;
    end
    err_cyc = cyc - last_fall_cyc;
    check("no_tmo_busy", 32'(txif.tx_busy), 32'd1);
    check("no_tmo_err",  32'(n_err - e0), 32'd0);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
`endif
    check("final_idle", 32'({txif.tx_busy, ps2_clock_oe, ps2_data_oe}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
